hamming_codec: RTL and testbench

HAMMING_CODEC -- requirements
Module: hamming_codec

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_parity_gen.sv | 20 ++
 rtl/hamming_codec.sv | 150 +++++++++++++++
 tb/tb_hamming_codec.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - widths, parity positions and data-to-position mapping for the Hamming(21,16) codec.
// HAMMING_SECDED_EN widens the external codeword by one overall-parity bit.
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 21;
    localparam int PAR_W  = 5;

`ifdef HAMMING_SECDED_EN
    localparam int XCODE_W = CODE_W + 1;
`else
    localparam int XCODE_W = CODE_W;
`endif

    // PAR_POS[k] = 2^k
    localparam logic [PAR_W-1:0][4:0] PAR_POS = {5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

    // Code position (1..21) holding enc_data[b]; bit 15 goes to position 3.
    function automatic logic [4:0] data_pos(input int b);
        logic [4:0] pos;
        int         n;
        pos = '0;
        n   = 0;
        for (int p = 1; p <= CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == DATA_W - 1 - b) begin
                    pos = 5'(p);
                end
                n++;
            end
        end
        return pos;
    endfunction

    // Vector index of a code position; position 1 is the MSB.
    function automatic logic [4:0] bit_idx(input logic [4:0] pos);
        return 5'(CODE_W) - pos;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// rtl/hamming_parity_gen.sv - XOR of code positions grouped by index bit; encoder parity and decoder syndrome.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] word,
    output logic [PAR_W-1:0]  syndrome
);

    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= CODE_W; p++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (((p >> k) & 1) != 0) begin
                    syndrome[k] = syndrome[k] ^ word[bit_idx(5'(p))];
                end
            end
        end
    end

endmodule

// File: rtl/hamming_codec.sv
// rtl/hamming_codec.sv - registered Hamming(21,16) encoder and single-error-correcting decoder.
// Optional HAMMING_SECDED_EN appends an overall parity bit for double-error detection.
module hamming_codec
    import hamming_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enc_valid,
    input  logic [DATA_W-1:0]  enc_data,
    output logic               enc_code_valid,
    output logic [XCODE_W-1:0] enc_code,
    input  logic               dec_valid,
    input  logic [XCODE_W-1:0] dec_code,
    output logic               dec_data_valid,
    output logic [DATA_W-1:0]  dec_data,
    output logic [PAR_W-1:0]   dec_syndrome,
    output logic               dec_corrected,
    output logic               dec_uncorrectable
);

    logic [CODE_W-1:0]  enc_word;
    logic [CODE_W-1:0]  enc_full;
    logic [PAR_W-1:0]   enc_par;
    logic [XCODE_W-1:0] enc_cw;

    logic [CODE_W-1:0]  dec_rx;
    logic [CODE_W-1:0]  dec_fixed;
    logic [PAR_W-1:0]   dec_syn;
    logic [DATA_W-1:0]  dec_extract;
    logic               dec_flip;
    logic               dec_corr_c;
    logic               dec_unc_c;

    logic               enc_code_valid_d, enc_code_valid_q;
    logic [XCODE_W-1:0] enc_code_d,       enc_code_q;
    logic               dec_data_valid_d, dec_data_valid_q;
    logic [DATA_W-1:0]  dec_data_d,       dec_data_q;
    logic [PAR_W-1:0]   dec_syndrome_d,   dec_syndrome_q;
    logic               dec_corrected_d,  dec_corrected_q;
    logic               dec_unc_d,        dec_unc_q;

    // Parity positions are left zero so the generator output is the parity itself.
    always_comb begin
        enc_word = '0;
        for (int b = 0; b < DATA_W; b++) begin
            enc_word[bit_idx(data_pos(b))] = enc_data[4'(b)];
        end
    end

    hamming_parity_gen u_enc_par (
        .word     (enc_word),
        .syndrome (enc_par)
    );

    always_comb begin
        enc_full = enc_word;
        for (int k = 0; k < PAR_W; k++) begin
            enc_full[bit_idx(PAR_POS[3'(k)])] = enc_par[3'(k)];
        end
`ifdef HAMMING_SECDED_EN
        enc_cw = {enc_full, ^enc_full};
`else
        enc_cw = enc_full;
`endif
    end

    assign dec_rx = dec_code[XCODE_W-1 -: CODE_W];

    hamming_parity_gen u_dec_syn (
        .word     (dec_rx),
        .syndrome (dec_syn)
    );

    always_comb begin
        dec_flip   = 1'b0;
        dec_corr_c = 1'b0;
        dec_unc_c  = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (dec_syn != '0) begin
            if (!(^dec_code)) begin
                dec_unc_c = 1'b1;
            end else if (dec_syn <= 5'(CODE_W)) begin
                dec_flip = 1'b1;
            end else begin
                dec_unc_c = 1'b1;
            end
        end else if (^dec_code) begin
            dec_corr_c = 1'b1;
        end
`else
        if (dec_syn != '0) begin
            if (dec_syn <= 5'(CODE_W)) begin
                dec_flip = 1'b1;
            end else begin
                dec_unc_c = 1'b1;
            end
        end
`endif
        dec_corr_c = dec_corr_c | dec_flip;

        dec_fixed = dec_rx;
        if (dec_flip) begin
            dec_fixed[bit_idx(dec_syn)] = ~dec_rx[bit_idx(dec_syn)];
        end
        dec_extract = '0;
        for (int b = 0; b < DATA_W; b++) begin
            dec_extract[4'(b)] = dec_fixed[bit_idx(data_pos(b))];
        end
    end

    // Data outputs hold when their path is idle; valids are single-cycle.
    always_comb begin
        enc_code_valid_d = enc_valid;
        enc_code_d       = enc_valid ? enc_cw : enc_code_q;
        dec_data_valid_d = dec_valid;
        dec_data_d       = dec_valid ? dec_extract : dec_data_q;
        dec_syndrome_d   = dec_valid ? dec_syn     : dec_syndrome_q;
        dec_corrected_d  = dec_valid ? dec_corr_c  : dec_corrected_q;
        dec_unc_d        = dec_valid ? dec_unc_c   : dec_unc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_code_valid_q <= 1'b0;
            enc_code_q       <= '0;
            dec_data_valid_q <= 1'b0;
            dec_data_q       <= '0;
            dec_syndrome_q   <= '0;
            dec_corrected_q  <= 1'b0;
            dec_unc_q        <= 1'b0;
        end else begin
            enc_code_valid_q <= enc_code_valid_d;
            enc_code_q       <= enc_code_d;
            dec_data_valid_q <= dec_data_valid_d;
            dec_data_q       <= dec_data_d;
            dec_syndrome_q   <= dec_syndrome_d;
            dec_corrected_q  <= dec_corrected_d;
            dec_unc_q        <= dec_unc_d;
        end
    end

    assign enc_code_valid    = enc_code_valid_q;
    assign enc_code          = enc_code_q;
    assign dec_data_valid    = dec_data_valid_q;
    assign dec_data          = dec_data_q;
    assign dec_syndrome      = dec_syndrome_q;
    assign dec_corrected     = dec_corrected_q;
    assign dec_uncorrectable = dec_unc_q;

endmodule

// File: tb/tb_hamming_codec.sv
// tb/tb_hamming_codec.sv - directed-vector bench for hamming_codec with a position-arithmetic reference model.
module tb_hamming_codec;
    import hamming_pkg::*;

    localparam int XW = XCODE_W;
    localparam int DPOS [16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  syn;
        logic        corr;
        logic        unc;
    } dres_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enc_valid;
    logic [15:0]   enc_data;
    logic          enc_code_valid;
    logic [XW-1:0] enc_code;
    logic          dec_valid;
    logic [XW-1:0] dec_code;
    logic          dec_data_valid;
    logic [15:0]   dec_data;
    logic [4:0]    dec_syndrome;
    logic          dec_corrected;
    logic          dec_uncorrectable;

    int n_checks = 0;
    int n_fail   = 0;

    logic          model_live = 1'b0;
    logic          exp_enc_v;
    logic [XW-1:0] exp_enc_code;
    logic          exp_dec_v;
    dres_t         exp_dec;

    hamming_codec dut (
        .clk               (clk),
        .rst               (rst),
        .enc_valid         (enc_valid),
        .enc_data          (enc_data),
        .enc_code_valid    (enc_code_valid),
        .enc_code          (enc_code),
        .dec_valid         (dec_valid),
        .dec_code          (dec_code),
        .dec_data_valid    (dec_data_valid),
        .dec_data          (dec_data),
        .dec_syndrome      (dec_syndrome),
        .dec_corrected     (dec_corrected),
        .dec_uncorrectable (dec_uncorrectable)
    );

    always #5 clk = ~clk;

    // Parity bits are chosen so the XOR of the indices of all set positions is zero.
    function automatic logic [XW-1:0] m_enc(input logic [15:0] d);
        logic [21:0]   c;
        int            s;
        logic [XW-1:0] r;
        c = '0;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            if (d[15-i]) begin
                c[DPOS[i]] = 1'b1;
                s = s ^ DPOS[i];
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (((s >> k) & 1) != 0) c[1 << k] = 1'b1;
        end
        r = '0;
        for (int p = 1; p <= 21; p++) r[XW-p] = c[p];
`ifdef HAMMING_SECDED_EN
        r[0] = ^c;
`endif
        return r;
    endfunction

    function automatic dres_t m_dec(input logic [XW-1:0] code);
        logic [21:0] c;
        int          s;
        logic        pe;
        logic        flip;
        dres_t       r;
        c = '0;
        s = 0;
        for (int p = 1; p <= 21; p++) begin
            c[p] = code[XW-p];
            if (c[p]) s = s ^ p;
        end
        r = '0;
`ifdef HAMMING_SECDED_EN
        pe = ^code;
        flip = (s != 0) && pe && (s <= 21);
        r.unc = (s != 0) && (!pe || s > 21);
        r.corr = flip || ((s == 0) && pe);
`else
        pe = 1'b0;
        flip = (s >= 1) && (s <= 21);
        r.unc = (s > 21) | pe;
        r.corr = flip;
`endif
        if (flip) c[s] = ~c[s];
        for (int i = 0; i < 16; i++) r.data[15-i] = c[DPOS[i]];
        r.syn = 5'(s);
        return r;
    endfunction

    function automatic logic [XW-1:0] flip_pos(input logic [XW-1:0] c, input int p);
        c[XW-p] = ~c[XW-p];
        return c;
    endfunction

    function automatic logic [20:0] top21(input logic [XW-1:0] c);
        return c[XW-1 -: 21];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [15:0] ed, input logic dv, input logic [XW-1:0] dc);
        enc_valid = ev;
        enc_data  = ed;
        dec_valid = dv;
        dec_code  = dc;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_live   = 1'b1;
            exp_enc_v    = 1'b0;
            exp_enc_code = '0;
            exp_dec_v    = 1'b0;
            exp_dec      = '0;
        end else if (model_live) begin
            exp_enc_v = enc_valid;
            if (enc_valid) exp_enc_code = m_enc(enc_data);
            exp_dec_v = dec_valid;
            if (dec_valid) exp_dec = m_dec(dec_code);
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("cmp_enc_code_valid", 32'(enc_code_valid), 32'(exp_enc_v));
            chk("cmp_enc_code", 32'(enc_code), 32'(exp_enc_code));
            chk("cmp_dec_data_valid", 32'(dec_data_valid), 32'(exp_dec_v));
            chk("cmp_dec_data", 32'(dec_data), 32'(exp_dec.data));
            chk("cmp_dec_syndrome", 32'(dec_syndrome), 32'(exp_dec.syn));
            chk("cmp_dec_corrected", 32'(dec_corrected), 32'(exp_dec.corr));
            chk("cmp_dec_uncorrectable", 32'(dec_uncorrectable), 32'(exp_dec.unc));
        end
    end

    initial begin
        logic [XW-1:0] cw;
        logic [20:0]   cw21;
        dres_t         dr;
        int            pairs [5][2];

        pairs = '{'{21, 3}, '{15, 16}, '{1, 2}, '{7, 9}, '{20, 11}};
        rst = 1'b1;
        drive(1'b1, 16'hFFFF, 1'b1, '1);
        tick();
        tick();

        chk("reset_enc_code_valid", 32'(enc_code_valid), 32'd0);
        chk("reset_enc_code", 32'(enc_code), 32'd0);
        chk("reset_dec_data_valid", 32'(dec_data_valid), 32'd0);
        chk("reset_dec_data", 32'(dec_data), 32'd0);
        chk("reset_dec_syndrome", 32'(dec_syndrome), 32'd0);
        chk("reset_dec_flags", 32'({dec_corrected, dec_uncorrectable}), 32'd0);

        cw21 = top21(m_enc(16'h34AA));
        chk("model_enc_34AA", 32'(cw21), 32'h1AE94A);
        dr = m_dec(flip_pos(m_enc(16'h34AA), 5));
        chk("model_dec_pos5", 32'(dr), 32'({16'h34AA, 5'd5, 1'b1, 1'b0}));

        rst = 1'b0;
        drive(1'b1, 16'h34AA, 1'b0, '0);
        tick();
        chk("enc_34AA_valid", 32'(enc_code_valid), 32'd1);
        chk("enc_34AA_code", 32'(top21(enc_code)), 32'h1AE94A);

        drive(1'b0, 16'h0000, 1'b1, flip_pos(m_enc(16'h34AA), 5));
        tick();
        chk("dec_pos5_data", 32'(dec_data), 32'h34AA);
        chk("dec_pos5_syn", 32'(dec_syndrome), 32'd5);
        chk("dec_pos5_corr", 32'(dec_corrected), 32'd1);
        chk("enc_idle_valid", 32'(enc_code_valid), 32'd0);
        chk("enc_idle_hold", 32'(top21(enc_code)), 32'h1AE94A);

        drive(1'b1, 16'h2C4A, 1'b1, m_enc(16'h2C4A));
        tick();
        chk("dec_clean_data", 32'(dec_data), 32'h2C4A);
        chk("dec_clean_syn", 32'(dec_syndrome), 32'd0);
        chk("dec_clean_flags", 32'({dec_corrected, dec_uncorrectable}), 32'd0);

        drive(1'b1, 16'hC86E, 1'b1, flip_pos(m_enc(16'hC86E), 13));
        tick();
        chk("dec_pos13_data", 32'(dec_data), 32'hC86E);
        chk("dec_pos13_syn", 32'(dec_syndrome), 32'd13);
        chk("dec_pos13_corr", 32'(dec_corrected), 32'd1);

        drive(1'b1, 16'h9ED5, 1'b1, flip_pos(m_enc(16'h9ED5), 21));
        tick();
        chk("dec_pos21_data", 32'(dec_data), 32'h9ED5);
        chk("dec_pos21_syn", 32'(dec_syndrome), 32'd21);
        chk("dec_pos21_corr", 32'(dec_corrected), 32'd1);

        drive(1'b0, 16'h1234, 1'b1, flip_pos(flip_pos(m_enc(16'h34AA), 8), 16));
        tick();
        chk("dec_double_syn", 32'(dec_syndrome), 32'd24);
        chk("dec_double_unc", 32'(dec_uncorrectable), 32'd1);
        chk("dec_double_corr", 32'(dec_corrected), 32'd0);
        chk("dec_double_data", 32'(dec_data), 32'h34AA);

        for (int p = 1; p <= 21; p++) begin
            drive(1'b1, 16'hA5C3 ^ 16'(p * 16'h0911), 1'b1, flip_pos(m_enc(16'h5A3C + 16'(p * 16'h0137)), p));
            tick();
        end

        drive(1'b0, 16'hDEAD, 1'b0, '1);
        tick();
        tick();

        for (int i = 0; i < 5; i++) begin
            cw = flip_pos(flip_pos(m_enc(16'h0F0F ^ 16'(i)), pairs[i][0]), pairs[i][1]);
            drive(1'b1, 16'h8001 << i, 1'b1, cw);
            tick();
        end

        drive(1'b1, 16'h1111, 1'b1, m_enc(16'h1111));
        tick();
        drive(1'b1, 16'h2222, 1'b1, flip_pos(m_enc(16'h2222), 7));
        rst = 1'b1;
        tick();
        chk("midrst_enc_valid", 32'(enc_code_valid), 32'd0);
        chk("midrst_enc_code", 32'(enc_code), 32'd0);
        chk("midrst_dec_valid", 32'(dec_data_valid), 32'd0);
        chk("midrst_dec_data", 32'(dec_data), 32'd0);

        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, '0);
        tick();
        chk("post_rst_no_enc_valid", 32'(enc_code_valid), 32'd0);
        chk("post_rst_no_dec_valid", 32'(dec_data_valid), 32'd0);

        drive(1'b1, 16'h34AA, 1'b1, flip_pos(m_enc(16'h9ED5), 3));
        tick();
        chk("fresh_enc_valid", 32'(enc_code_valid), 32'd1);
        chk("fresh_enc_code", 32'(top21(enc_code)), 32'h1AE94A);
        chk("fresh_dec_valid", 32'(dec_data_valid), 32'd1);
        chk("fresh_dec_data", 32'(dec_data), 32'h9ED5);
        chk("fresh_dec_syn", 32'(dec_syndrome), 32'd3);

        drive(1'b0, 16'h0000, 1'b0, '0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
